des_round_sequencer: RTL and testbench

- Control FSM for the iterative single-round DES datapath: expansion, key mix, S-boxes, P-permutation, and the C/D key registers.
- Accepts a start request with an encrypt/decrypt mode and sequences load, 16 rounds and a final-swap/FP capture.
- Drives the per-round key-schedule shift amount and direction.
- Presents the result through a valid/ready handshake. Sits between the host-side block interface and the round datapath; owns no data bits.

---
 rtl/des_round_sequencer.sv | 141 ++++++++++++++
 tb/tb_des_round_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
// ---------------------------------------------------------------------------
// des_round_sequencer
//
// Control FSM for an iterative single-round DES datapath. It accepts a block
// request, runs one load cycle and NUM_ROUNDS round cycles, then one
// final-swap/FP capture cycle. It then holds the result valid until the host
// takes it. The key-schedule rotate amount and direction for each round are
// generated here. No data bits pass through this block.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start_valid    host block request
//   start_ready    request can be accepted (IDLE)
//   start_decrypt  mode captured on the start handshake (1 = decrypt)
//   abort          cancel the operation in flight (ignored in IDLE)
//   dp_load        datapath loads IP(data) -> L/R and PC1(key) -> C/D
//   dp_round_en    datapath performs one round this cycle
//   dp_round_num   current round 1..NUM_ROUNDS, 0 outside ROUND
//   dp_shift_amt   C/D rotate amount this round (0, 1 or 2)
//   dp_shift_dir   0 rotate left (encrypt), 1 rotate right (decrypt)
//   dp_final       datapath applies R16L16 swap + FP into output register
//   out_valid      result in datapath output register is valid
//   out_ready      host consumes the result (only observed in DONE)
//   busy           high in every state except IDLE
// ---------------------------------------------------------------------------
module des_round_sequencer #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       start_decrypt,
    input  logic       abort,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic [4:0] dp_round_num,
    output logic [1:0] dp_shift_amt,
    output logic       dp_shift_dir,
    output logic       dp_final,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    logic [2:0] state_q, state_d;
    logic [4:0] cnt_q,   cnt_d;
    logic       mode_q,  mode_d;

    // Per-round C/D rotate amount. Decrypt skips the round-1 rotate so the
    // total is 27 instead of 28, which makes the first subkey K16 once the
    // rotation runs rightwards.
    function automatic logic [1:0] shift_amt(input logic [4:0] rnd,
                                             input logic       dec);
        logic [1:0] amt;
        if (dec && rnd == 5'd1)
            amt = 2'd0;
        else if (rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16)
            amt = 2'd1;
        else
            amt = 2'd2;
        return amt;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    state_d = S_LOAD;
                    mode_d  = start_decrypt;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
                cnt_d   = 5'd1;
            end
            S_ROUND: begin
                if (cnt_q == LAST_ROUND) begin
                    state_d = S_FINAL;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_FINAL: state_d = S_DONE;
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
        // Abort overrides everything outside IDLE, including out_ready in
        // DONE; the pending result is simply dropped.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // All outputs are pure decodes of registered state.
    logic in_round;
    assign in_round = (state_q == S_ROUND);

    assign start_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign dp_load      = (state_q == S_LOAD);
    assign dp_round_en  = in_round;
    assign dp_round_num = in_round ? cnt_q : 5'd0;
    assign dp_shift_amt = in_round ? shift_amt(cnt_q, mode_q) : 2'd0;
    assign dp_shift_dir = in_round & mode_q;
    assign dp_final     = (state_q == S_FINAL);
    assign out_valid    = (state_q == S_DONE);

endmodule

// File: tb/tb_des_round_sequencer.sv
module tb_des_round_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid, start_ready, start_decrypt, abort;
    logic       dp_load, dp_round_en, dp_shift_dir, dp_final;
    logic [4:0] dp_round_num;
    logic [1:0] dp_shift_amt;
    logic       out_valid, out_ready, busy;

    des_round_sequencer #(.NUM_ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_decrypt(start_decrypt),
        .abort        (abort),
        .dp_load      (dp_load),
        .dp_round_en  (dp_round_en),
        .dp_round_num (dp_round_num),
        .dp_shift_amt (dp_shift_amt),
        .dp_shift_dir (dp_shift_dir),
        .dp_final     (dp_final),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // One record per cycle after the start handshake: input mode plus the
    // expected datapath-control outputs for that cycle.
    typedef struct {
        logic       mode_in;
        logic       ld;
        logic       ren;
        logic [4:0] num;
        logic [1:0] amt;
        logic       dir;
        logic       fin;
        logic       ov;
    } vec_t;

    vec_t enc_tab [1:19];
    vec_t dec_tab [1:19];

    logic [1:0] enc_amt [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [1:0] dec_amt [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    localparam logic [13:0] IDLE_VEC = {1'b1, 13'b0};

    int tests  = 0;
    int failed = 0;

    // {start_ready, load, round_en, num, amt, dir, final, out_valid, busy}
    function automatic logic [13:0] dut_vec();
        return {start_ready, dp_load, dp_round_en, dp_round_num, dp_shift_amt,
                dp_shift_dir, dp_final, out_valid, busy};
    endfunction

    function automatic logic [13:0] tab_vec(input vec_t t);
        return {1'b0, t.ld, t.ren, t.num, t.amt, t.dir, t.fin, t.ov, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [13:0] act,
                       input logic [13:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert start for one edge; returns in cycle 1 (the LOAD cycle).
    task automatic start_block(input logic dec);
        start_valid   = 1'b1;
        start_decrypt = dec;
        step();
        start_valid = 1'b0;
    endtask

    // Checks cycles 1..19 of a block that was just started.
    task automatic check_run(input string tag, input logic dec, input logic tog);
        int   sum;
        vec_t t;
        sum = 0;
        for (int c = 1; c <= 19; c++) begin
            if (c > 1) step();
            if (tog && c == 5) start_decrypt = 1'b0;
            if (tog && c == 6) start_decrypt = 1'b1;
            t = dec ? dec_tab[c] : enc_tab[c];
            if (dp_round_en) sum += int'(dp_shift_amt);
            chk($sformatf("%s cyc%0d", tag, c), dut_vec(), tab_vec(t));
        end
        chk($sformatf("%s shift_sum", tag), 14'(sum), dec ? 14'd27 : 14'd28);
    endtask

    initial begin
        logic final_seen;

        for (int c = 1; c <= 19; c++) begin
            enc_tab[c] = '{mode_in: 1'b0, ld: (c == 1), ren: (c >= 2 && c <= 17),
                           num: 5'd0, amt: 2'd0, dir: 1'b0,
                           fin: (c == 18), ov: (c == 19)};
            dec_tab[c] = enc_tab[c];
            dec_tab[c].mode_in = 1'b1;
            if (c >= 2 && c <= 17) begin
                enc_tab[c].num = 5'(c - 1);
                enc_tab[c].amt = enc_amt[c-2];
                dec_tab[c].num = 5'(c - 1);
                dec_tab[c].amt = dec_amt[c-2];
                dec_tab[c].dir = 1'b1;
            end
        end

        rst_n = 1'b0; start_valid = 1'b0; start_decrypt = 1'b0;
        abort = 1'b0; out_ready = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset", dut_vec(), IDLE_VEC);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", dut_vec(), IDLE_VEC);

        // Encrypt, then decrypt issued at the minimum interval
        out_ready = 1'b1;
        start_block(enc_tab[1].mode_in);
        check_run("enc", 1'b0, 1'b0);
        step();
        chk("enc_cyc20_idle", dut_vec(), IDLE_VEC);
        start_block(dec_tab[1].mode_in);
        check_run("dec", 1'b1, 1'b1);
        step();
        chk("dec_return_idle", dut_vec(), IDLE_VEC);

        // Backpressure
        out_ready = 1'b0;
        start_block(1'b0);
        check_run("bp", 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp_hold%0d", i), dut_vec(), tab_vec(enc_tab[19]));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", dut_vec(), IDLE_VEC);

        // Abort ignored in IDLE; abort with start accepts; abort in LOAD
        abort = 1'b1;
        step();
        chk("abort_idle_ignored", dut_vec(), IDLE_VEC);
        start_valid = 1'b1; start_decrypt = 1'b0;
        step();
        start_valid = 1'b0; abort = 1'b0;
        chk("abort_with_start", dut_vec(), tab_vec(enc_tab[1]));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_in_load", dut_vec(), IDLE_VEC);

        // Abort at round 7, then a full encrypt run
        start_block(1'b0);
        repeat (7) step();
        chk("at_round7", dut_vec(), tab_vec(enc_tab[8]));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_round7", dut_vec(), IDLE_VEC);
        out_ready = 1'b1;
        start_block(1'b0);
        check_run("post_abort", 1'b0, 1'b0);
        step();
        chk("post_abort_idle", dut_vec(), IDLE_VEC);

        // Abort in DONE beats out_ready
        out_ready = 1'b0;
        start_block(1'b1);
        repeat (18) step();
        chk("done_before_abort", dut_vec(), tab_vec(dec_tab[19]));
        abort = 1'b1; out_ready = 1'b1;
        step();
        abort = 1'b0; out_ready = 1'b0;
        chk("abort_in_done", dut_vec(), IDLE_VEC);

        // Asynchronous reset during round 10
        start_block(1'b0);
        repeat (10) step();
        chk("at_round10", dut_vec(), tab_vec(enc_tab[11]));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_now", dut_vec(), IDLE_VEC);
        final_seen = 1'b0;
        repeat (2) begin
            step();
            final_seen |= dp_final;
        end
        rst_n = 1'b1;
        repeat (25) begin
            step();
            final_seen |= dp_final | ~start_ready;
        end
        chk("no_final_after_reset", 14'(final_seen), 14'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
